fwd_hazard_scoreboard: RTL

- Parametrised successor to the pipeline forwarding logic: generates forwarding selects for NSRC source operands of the instruction in EX.
- Adds a per-register latency scoreboard that tracks in-flight producers (ALU, load, multi-cycle units).
- Raises a stall for an ID-stage consumer whose producer's result will not be forwardable in time. Keeps a saturating stall-cycle counter.
- Sits between the ID/EX pipeline control and the EX-stage operand muxes.

---
 rtl/fwd_hazard_scoreboard.sv | 96 +++++++++
 1 files changed

// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding selects for the EX stage plus a per-register latency scoreboard
// that stalls ID-stage consumers whose producer result cannot be forwarded in time.
module fwd_hazard_scoreboard #(
  parameter int unsigned AW      = 5,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned MAX_LAT = 4,
  parameter int unsigned SCW     = 16,
  localparam int unsigned LW     = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_regwrite,
  input  logic [AW-1:0]     issue_rd,
  input  logic [LW-1:0]     issue_lat,
  input  logic [NSRC*AW-1:0] id_rs,
  input  logic [NSRC-1:0]   id_src_used,
  input  logic [NSRC*AW-1:0] ex_rs,
  input  logic              ex_mem_regwrite,
  input  logic [AW-1:0]     ex_mem_rd,
  input  logic              mem_wb_regwrite,
  input  logic [AW-1:0]     mem_wb_rd,
  output logic [2*NSRC-1:0] fw_sel,
  output logic              stall,
  output logic [SCW-1:0]    stall_count
);

  localparam int unsigned NREG = 2 ** AW;

  // Entry 0 exists only to keep indexing simple; it is never written or read.
  logic [LW-1:0] cnt [NREG];
  logic [LW-1:0] eff_lat;
  logic          load;
  logic          stall_raw;

  always_comb begin
    if (issue_lat == '0) begin
      eff_lat = LW'(1);
    end else if (issue_lat > LW'(MAX_LAT)) begin
      eff_lat = LW'(MAX_LAT);
    end else begin
      eff_lat = issue_lat;
    end
  end

  assign load = issue_valid & issue_regwrite & (issue_rd != '0) & ~stall;

  // cnt == 1 is still covered by EX/MEM or MEM/WB forwarding, so only > 1 stalls.
  always_comb begin
    stall_raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int r = 1; r < NREG; r++) begin
        if (id_src_used[i] && id_rs[i*AW +: AW] == AW'(r) && cnt[r] > LW'(1)) begin
          stall_raw = 1'b1;
        end
      end
    end
  end

  assign stall = rst_n & stall_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 1; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      stall_count <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (load && issue_rd == AW'(r)) begin
          cnt[r] <= eff_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
      if (stall && stall_count != '1) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  // EX/MEM is checked first so the most recent value wins when both stages match.
  always_comb begin
    fw_sel = '0;
    if (rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        if (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == ex_rs[i*AW +: AW]) begin
          fw_sel[2*i +: 2] = 2'b10;
        end else if (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == ex_rs[i*AW +: AW]) begin
          fw_sel[2*i +: 2] = 2'b01;
        end
      end
    end
  end

endmodule
